key_code_decoder: RTL and testbench

- Receiver end of the 8-bit keypad selector code.
- Samples the code bus and requires a code to stay stable for DEBOUNCE_CYCLES before accepting it.
- Decodes an accepted code back to a single key index (K1..K5) and reports press/release events to the downstream controller through a valid/ack handshake.
- Stable codes that are not in the code table raise an error flag.

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/code_debouncer.sv | 48 ++++
 rtl/key_code_decoder.sv | 159 +++++++++++++++
 tb/tb_key_code_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad selector definitions: code table, key numbering, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    // Selector code table; every other byte value is an invalid code
    localparam logic [7:0] CODE_NONE = 8'h00;
    localparam logic [7:0] CODE_K1   = 8'h72;
    localparam logic [7:0] CODE_K2   = 8'h03;
    localparam logic [7:0] CODE_K3   = 8'hBB;
    localparam logic [7:0] CODE_K4   = 8'hE3;
    localparam logic [7:0] CODE_K5   = 8'h37;

    // Key numbers 1..5; 0 means no key, 7 marks a code outside the table
    typedef logic [2:0] key_t;

    localparam key_t KEY_NONE    = 3'd0;
    localparam key_t KEY_K1      = 3'd1;
    localparam key_t KEY_K2      = 3'd2;
    localparam key_t KEY_K3      = 3'd3;
    localparam key_t KEY_K4      = 3'd4;
    localparam key_t KEY_K5      = 3'd5;
    localparam key_t KEY_INVALID = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_ERR     = 2'd2
    } state_e;

    function automatic key_t code_to_key(input logic [7:0] code);
        key_t k;
        case (code)
            CODE_NONE: k = KEY_NONE;
            CODE_K1:   k = KEY_K1;
            CODE_K2:   k = KEY_K2;
            CODE_K3:   k = KEY_K3;
            CODE_K4:   k = KEY_K4;
            CODE_K5:   k = KEY_K5;
            default:   k = KEY_INVALID;
        endcase
        return k;
    endfunction

    function automatic logic [4:0] key_to_onehot(input key_t k);
        logic [4:0] oh;
        case (k)
            KEY_K1:  oh = 5'b00001;
            KEY_K2:  oh = 5'b00010;
            KEY_K3:  oh = 5'b00100;
            KEY_K4:  oh = 5'b01000;
            KEY_K5:  oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/code_debouncer.sv
// Registers the selector code and accepts it once it has been stable for DEBOUNCE_CYCLES samples.
// Latency: accept pulses DEBOUNCE_CYCLES cycles after the sample register picks up a new code.
// Backpressure: none; accept is a one-cycle pulse per stable period and must be consumed.
module code_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    output logic       accept,
    output logic [7:0] accept_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               SINGLE  = (DEBOUNCE_CYCLES == 1);

    logic [7:0]       samp;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic             changed;

    assign changed = (samp != cand);

    // Accept on the cycle the count reaches its target; the counter then
    // saturates, so this fires only once until samp changes again.
    assign accept      = changed ? SINGLE : (cnt == CNT_PRE);
    assign accept_code = samp;

    // Sample register, candidate reload and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 8'h00;
            cand <= 8'h00;
            cnt  <= '0;
        end else begin
            samp <= code_in;
            if (changed) begin
                cand <= samp;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_code_decoder.sv
// Decodes debounced keypad selector codes into press/release events and a live one-hot key state.
// Latency: event appears DEBOUNCE_CYCLES+1 cycles after a code_in change; a key-change press follows its release ack.
// Backpressure: evt_valid held until evt_ack; events arriving while one is unacked are dropped and flag overflow.
module key_code_decoder import keypad_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       evt_ack,
    output logic       evt_valid,
    output logic       evt_press,
    output logic [2:0] evt_key,
    output logic [4:0] key_onehot,
    output logic       code_err,
    output logic       overflow
);

    logic       acc;
    logic [7:0] acc_code;
    key_t       acc_key;

    state_e     state, state_nxt;
    key_t       cur_key, cur_key_nxt;

    // Event produced by the FSM this cycle, plus an optional follow-up press
    logic       gen_vld;
    logic       gen_press;
    key_t       gen_key;
    logic       pq_set;
    key_t       pq_key;

    // One-entry slot holding the press half of a direct key change
    logic       pend_vld;
    key_t       pend_key;

    logic       slot_free;

    code_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .accept      (acc),
        .accept_code (acc_code)
    );

    assign slot_free  = !evt_valid || evt_ack;
    assign code_err   = (state == ST_ERR);
    assign key_onehot = (state == ST_PRESSED) ? key_to_onehot(cur_key) : 5'b00000;

    // Key-state FSM: reacts only to accepted codes and decides which event to emit
    always_comb begin
        state_nxt   = state;
        cur_key_nxt = cur_key;
        gen_vld     = 1'b0;
        gen_press   = 1'b0;
        gen_key     = KEY_NONE;
        pq_set      = 1'b0;
        pq_key      = KEY_NONE;
        acc_key     = code_to_key(acc_code);
        if (acc) begin
            case (state)
                ST_IDLE: begin
                    if (acc_key == KEY_INVALID) begin
                        state_nxt = ST_ERR;
                    end else if (acc_key != KEY_NONE) begin
                        state_nxt   = ST_PRESSED;
                        cur_key_nxt = acc_key;
                        gen_vld     = 1'b1;
                        gen_press   = 1'b1;
                        gen_key     = acc_key;
                    end
                end
                ST_PRESSED: begin
                    if (acc_key != cur_key) begin
                        gen_vld   = 1'b1;
                        gen_press = 1'b0;
                        gen_key   = cur_key;
                        if (acc_key == KEY_NONE) begin
                            state_nxt   = ST_IDLE;
                            cur_key_nxt = KEY_NONE;
                        end else if (acc_key == KEY_INVALID) begin
                            state_nxt   = ST_ERR;
                            cur_key_nxt = KEY_NONE;
                        end else begin
                            pq_set      = 1'b1;
                            pq_key      = acc_key;
                            cur_key_nxt = acc_key;
                        end
                    end
                end
                ST_ERR: begin
                    if (acc_key == KEY_NONE) begin
                        state_nxt = ST_IDLE;
                    end else if (acc_key != KEY_INVALID) begin
                        state_nxt   = ST_PRESSED;
                        cur_key_nxt = acc_key;
                        gen_vld     = 1'b1;
                        gen_press   = 1'b1;
                        gen_key     = acc_key;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State registers plus the event output register, pending slot and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_key   <= KEY_NONE;
            evt_valid <= 1'b0;
            evt_press <= 1'b0;
            evt_key   <= KEY_NONE;
            pend_vld  <= 1'b0;
            pend_key  <= KEY_NONE;
            overflow  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_key <= cur_key_nxt;

            if (evt_valid && evt_ack) begin
                evt_valid <= 1'b0;
            end

            // The pending press goes out before anything new; a fresh event
            // colliding with it in the same cycle is lost.
            if (slot_free && pend_vld) begin
                evt_valid <= 1'b1;
                evt_press <= 1'b1;
                evt_key   <= pend_key;
                pend_vld  <= 1'b0;
                if (gen_vld) begin
                    overflow <= 1'b1;
                end
            end else if (slot_free && gen_vld) begin
                evt_valid <= 1'b1;
                evt_press <= gen_press;
                evt_key   <= gen_key;
            end else if (gen_vld) begin
                overflow <= 1'b1;
            end

            if (pq_set) begin
                if (pend_vld && !slot_free) begin
                    overflow <= 1'b1;
                end
                pend_vld <= 1'b1;
                pend_key <= pq_key;
            end
        end
    end

endmodule

// File: tb/tb_key_code_decoder.sv
// Directed bench for key_code_decoder with an event scoreboard.
// Latency: events are matched against a queue as the DUT loads each new one.
// Backpressure: evt_ack is driven by the stimulus sequence.
module tb_key_code_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] code_in;
    logic       evt_ack;
    logic       evt_valid;
    logic       evt_press;
    logic [2:0] evt_key;
    logic [4:0] key_onehot;
    logic       code_err;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected events: {press, key[2:0]}
    logic [3:0] exp_q[$];

    logic last_vld = 1'b0;
    logic last_ack = 1'b0;

    key_code_decoder #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .evt_ack    (evt_ack),
        .evt_valid  (evt_valid),
        .evt_press  (evt_press),
        .evt_key    (evt_key),
        .key_onehot (key_onehot),
        .code_err   (code_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic press, input logic [2:0] key);
        exp_q.push_back({press, key});
    endtask

    task automatic ack1();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            tick();
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: a new event is present when evt_valid rises or is reloaded right after an ack
    always @(negedge clk) begin
        logic [3:0] exp_ev;
        if (evt_valid && (!last_vld || last_ack)) begin
            chk("evt_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                exp_ev = exp_q.pop_front();
                chk("evt_press", int'(evt_press), int'(exp_ev[3]));
                chk("evt_key", int'(evt_key), int'(exp_ev[2:0]));
            end
        end
        last_vld = evt_valid;
        last_ack = evt_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        code_in = 8'h00;
        evt_ack = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_press", int'(evt_press), 0);
        chk("rst_key", int'(evt_key), 0);
        chk("rst_onehot", int'(key_onehot), 0);
        chk("rst_err", int'(code_err), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("idle_quiet", int'(evt_valid), 0);

        // K1 press: event exactly 5 cycles after the change
        code_in = 8'h72;
        push(1'b1, 3'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("k1_early", int'(evt_valid), 0);
        end
        tick();
        chk("k1_valid", int'(evt_valid), 1);
        chk("k1_onehot", int'(key_onehot), 5'b00001);
        tick();
        ack1();
        chk("k1_acked", int'(evt_valid), 0);

        // K1 release
        code_in = 8'h00;
        push(1'b0, 3'd1);
        repeat (5) tick();
        chk("rel1_valid", int'(evt_valid), 1);
        chk("rel1_press", int'(evt_press), 0);
        chk("rel1_onehot", int'(key_onehot), 0);
        ack1();

        // Bounce on K2 then stable: exactly one press, only after 4 stable cycles
        for (int i = 0; i < 10; i++) begin
            code_in = (i % 2 == 0) ? 8'h03 : 8'h00;
            tick();
            chk("bounce_quiet", int'(evt_valid), 0);
        end
        code_in = 8'h03;
        push(1'b1, 3'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("k2_early", int'(evt_valid), 0);
        end
        tick();
        chk("k2_valid", int'(evt_valid), 1);
        chk("k2_onehot", int'(key_onehot), 5'b00010);
        ack1();
        repeat (6) tick();
        chk("k2_single", int'(evt_valid), 0);
        evt_ack = 1'b1;
        code_in = 8'h00;
        push(1'b0, 3'd2);
        drain("k2_rel_drain", 20);

        // Direct K3 -> K4 change with ack held high
        code_in = 8'hBB;
        push(1'b1, 3'd3);
        drain("k3_drain", 20);
        chk("k3_onehot", int'(key_onehot), 5'b00100);
        code_in = 8'hE3;
        push(1'b0, 3'd3);
        push(1'b1, 3'd4);
        repeat (4) tick();
        chk("k3_still", int'(key_onehot), 5'b00100);
        tick();
        chk("chg_rel_valid", int'(evt_valid), 1);
        chk("chg_rel_press", int'(evt_press), 0);
        chk("chg_rel_key", int'(evt_key), 3);
        chk("k4_onehot", int'(key_onehot), 5'b01000);
        tick();
        chk("chg_prs_valid", int'(evt_valid), 1);
        chk("chg_prs_press", int'(evt_press), 1);
        chk("chg_prs_key", int'(evt_key), 4);
        code_in = 8'h00;
        push(1'b0, 3'd4);
        drain("k4_rel_drain", 20);

        // Invalid code from IDLE, then recovery on K5
        code_in = 8'hFF;
        repeat (4) tick();
        chk("err_early", int'(code_err), 0);
        tick();
        chk("err_set", int'(code_err), 1);
        chk("err_noevt", int'(evt_valid), 0);
        code_in = 8'h37;
        push(1'b1, 3'd5);
        repeat (5) tick();
        chk("err_clr", int'(code_err), 0);
        chk("k5_valid", int'(evt_valid), 1);
        chk("k5_onehot", int'(key_onehot), 5'b10000);
        code_in = 8'h00;
        push(1'b0, 3'd5);
        drain("k5_rel_drain", 20);

        // Overflow: no ack, release gets dropped
        evt_ack = 1'b0;
        repeat (2) tick();
        code_in = 8'h72;
        push(1'b1, 3'd1);
        repeat (5) tick();
        chk("ovf_press", int'(evt_valid), 1);
        chk("ovf_before", int'(overflow), 0);
        code_in = 8'h00;
        repeat (6) tick();
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_valid", int'(evt_valid), 1);
        chk("ovf_key", int'(evt_key), 1);
        chk("ovf_evpress", int'(evt_press), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_rst", int'(overflow), 0);
        chk("ovf_rst_valid", int'(evt_valid), 0);
        repeat (6) tick();

        // Reset while PRESSED K4 with an unacked event
        code_in = 8'hE3;
        push(1'b1, 3'd4);
        repeat (5) tick();
        chk("k4b_valid", int'(evt_valid), 1);
        chk("k4b_onehot", int'(key_onehot), 5'b01000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prst_valid", int'(evt_valid), 0);
        chk("prst_press", int'(evt_press), 0);
        chk("prst_key", int'(evt_key), 0);
        chk("prst_onehot", int'(key_onehot), 0);
        chk("prst_err", int'(code_err), 0);
        chk("prst_ovf", int'(overflow), 0);
        push(1'b1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("k4c_early", int'(evt_valid), 0);
        end
        tick();
        chk("k4c_valid", int'(evt_valid), 1);
        chk("k4c_key", int'(evt_key), 4);
        ack1();
        evt_ack = 1'b1;
        code_in = 8'h00;
        push(1'b0, 3'd4);
        drain("final_drain", 20);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
